// File: rtl/imdct_pkg.sv
// rtl/imdct_pkg.sv - shared constants, requester ids and state encoding for the IMDCT twiddle ROM arbiter.
package imdct_pkg;

    localparam int SHORT_BASE = 0;
    localparam int SHORT_LEN  = 64;
    localparam int LONG_BASE  = 64;
    localparam int LONG_LEN   = 512;

    localparam int REQ_PRE  = 0;
    localparam int REQ_POST = 1;

    // Burst counters must hold LONG_LEN itself, word indices only LONG_LEN-1.
    localparam int LEN_W = 10;
    localparam int IDX_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/imdct_rr_arb2.sv
// rtl/imdct_rr_arb2.sv - two-way grant picker, round-robin or fixed priority when IMDCT_TWARB_PRIO_EN is defined.
module imdct_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_id
);
    import imdct_pkg::*;

    assign gnt_valid = |req;

`ifdef IMDCT_TWARB_PRIO_EN
    assign gnt_id = req[REQ_POST];

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, take};
`else
    // Winner of the last contested grant; uncontested grants leave it alone.
    logic last_win;

    always_comb begin
        gnt_id = req[REQ_POST];
        if (&req) begin
            gnt_id = ~last_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win <= 1'b1;
        end else if (take && (&req)) begin
            last_win <= gnt_id;
        end
    end
`endif

endmodule

// File: rtl/imdct_twiddle_arb.sv
// rtl/imdct_twiddle_arb.sv - shares the twiddle ROM between pre/post twiddle requesters, one locked burst at a time.
// Optional fixed priority (post-twiddle wins) when IMDCT_TWARB_PRIO_EN is defined.
module imdct_twiddle_arb #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int SHORT_BASE = imdct_pkg::SHORT_BASE,
    parameter int SHORT_LEN  = imdct_pkg::SHORT_LEN,
    parameter int LONG_BASE  = imdct_pkg::LONG_BASE,
    parameter int LONG_LEN   = imdct_pkg::LONG_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_start,
    input  logic [1:0]        req_long,
    output logic [1:0]        req_busy,
    output logic [1:0]        tw_valid,
    input  logic [1:0]        tw_ready,
    output logic [DATA_W-1:0] tw_data,
    output logic [8:0]        tw_index,
    output logic              tw_last,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);
    import imdct_pkg::*;

    state_t state, state_nxt;

    logic [1:0]        pend;
    logic [1:0]        pend_long;
    logic              owner;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issue_cnt;
    logic              dv;
    logic [IDX_W-1:0]  idx;

    logic gnt_valid;
    logic gnt_id;
    logic grant;
    logic own_ready;
    logic active;

    imdct_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .take      (grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign own_ready = tw_ready[owner];
    assign active    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Issue whenever the output register is empty or being emptied this cycle.
                rom_en = ~dv | own_ready;
                if (rom_en && (issue_cnt == len - LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dv && own_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            pend_long <= '0;
            owner     <= 1'b0;
            base      <= '0;
            len       <= '0;
            issue_cnt <= '0;
            dv        <= 1'b0;
            idx       <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_start[i] && !req_busy[i]) begin
                    pend[i]      <= 1'b1;
                    pend_long[i] <= req_long[i];
                end
            end

            if (grant) begin
                owner     <= gnt_id;
                base      <= pend_long[gnt_id] ? ADDR_W'(LONG_BASE) : ADDR_W'(SHORT_BASE);
                len       <= pend_long[gnt_id] ? LEN_W'(LONG_LEN) : LEN_W'(SHORT_LEN);
                issue_cnt <= '0;
                pend[gnt_id] <= 1'b0;
            end

            // ROM data lands one cycle after the read, so the index rides along with it.
            if (rom_en) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
                idx       <= issue_cnt[IDX_W-1:0];
                dv        <= 1'b1;
            end else if (dv && own_ready) begin
                dv <= 1'b0;
            end
        end
    end

    assign req_busy = pend | ({owner, ~owner} & {2{active}});
    assign tw_valid = {dv & owner, dv & ~owner};
    assign tw_data  = dv ? rom_dout : '0;
    assign tw_index = idx;
    assign tw_last  = dv & ({1'b0, idx} == len - LEN_W'(1));
    assign rom_addr = (state == RUN) ? (base + ADDR_W'(issue_cnt)) : '0;

endmodule

// File: tb/tb_imdct_twiddle_arb.sv
// tb/tb_imdct_twiddle_arb.sv - self-checking bench for imdct_twiddle_arb against a burst-level reference model.
module tb_imdct_twiddle_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_start = 2'b00;
    logic [1:0]  req_long = 2'b00;
    logic [1:0]  req_busy;
    logic [1:0]  tw_valid;
    logic [1:0]  tw_ready = 2'b00;
    logic [63:0] tw_data;
    logic [8:0]  tw_index;
    logic        tw_last;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [63:0] rom_dout = 64'd0;

    imdct_twiddle_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_start (req_start),
        .req_long  (req_long),
        .req_busy  (req_busy),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .tw_data   (tw_data),
        .tw_index  (tw_index),
        .tw_last   (tw_last),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input logic [9:0] a);
        logic [31:0] x;
        x = {22'd0, a};
        return {x * 32'h9E37_79B1, 32'h5A5A_0000 ^ (x * 32'd7 + 32'd3)};
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_word(rom_addr);
    end

    typedef struct {
        int          id;
        logic [63:0] data;
        int          index;
        logic        last;
    } word_t;

    word_t got[$];
    word_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    rmode = 0;
    int    first_valid[2];
    int    last_hs[2];
    int    busy_low;
    int    c0;
    int    order0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc_step(input logic [1:0] st, input logic [1:0] lg);
        word_t w;
        @(negedge clk);
        req_start = st;
        req_long  = lg;
        tw_ready  = (rmode == 1) ? 2'($urandom_range(0, 3)) : 2'b11;
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (tw_valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
            if (tw_valid[i] && tw_ready[i]) begin
                w.id = i; w.data = tw_data; w.index = int'(tw_index); w.last = tw_last;
                got.push_back(w);
                last_hs[i] = cyc;
            end
        end
    endtask

    task automatic expect_burst(input int id, input bit lng);
        word_t w;
        int base, len;
        base = lng ? 64 : 0;
        len  = lng ? 512 : 64;
        for (int n = 0; n < len; n++) begin
            w.id = id; w.data = rom_word(10'(base + n)); w.index = n; w.last = (n == len - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic clear_log();
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            first_valid[i] = -1;
            last_hs[i] = -1;
        end
    endtask

    task automatic pulse(input logic [1:0] st, input logic [1:0] lg);
        cyc_step(st, lg);
        cyc_step(2'b00, 2'b00);
    endtask

    task automatic run_idle(input string tag, input int budget);
        for (int n = 0; n < budget && req_busy != 2'b00; n++) cyc_step(2'b00, 2'b00);
        busy_low = cyc;
        chk({tag, " idle timeout"}, req_busy, 2'b00);
    endtask

    task automatic check_words(input string tag);
        int n;
        chk({tag, " count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s w%0d id", tag, i), got[i].id, exp_q[i].id);
            chk($sformatf("%s w%0d data", tag, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s w%0d index", tag, i), got[i].index, exp_q[i].index);
            chk($sformatf("%s w%0d last", tag, i), got[i].last, exp_q[i].last);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " req_busy"}, req_busy, 2'b00);
        chk({tag, " tw_valid"}, tw_valid, 2'b00);
        chk({tag, " tw_data"}, tw_data, 64'd0);
        chk({tag, " tw_index"}, tw_index, 9'd0);
        chk({tag, " tw_last"}, tw_last, 1'b0);
        chk({tag, " rom_en"}, rom_en, 1'b0);
        chk({tag, " rom_addr"}, rom_addr, 10'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_start = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Short burst, always ready, with start-to-data latency
        clear_log();
        expect_burst(0, 0);
        cyc_step(2'b01, 2'b00);
        c0 = cyc;
        cyc_step(2'b00, 2'b00);
        chk("short busy rise", req_busy, 2'b01);
        chk("short no early rom_en", rom_en, 1'b0);
        cyc_step(2'b00, 2'b00);
        chk("short first rom_en", rom_en, 1'b1);
        chk("short first addr", rom_addr, 10'd0);
        run_idle("short0", 400);
        check_words("short0");
        chk("short first valid cycle", first_valid[0], c0 + 3);
        chk("short busy fall", busy_low, last_hs[0] + 1);

        // Long burst on requester 1 under random backpressure
        clear_log();
        rmode = 1;
        expect_burst(1, 1);
        pulse(2'b10, 2'b10);
        run_idle("long1", 4000);
        check_words("long1");
        rmode = 0;

        // Simultaneous starts after reset, then the same pattern again
        do_reset();
`ifdef IMDCT_TWARB_PRIO_EN
        order0 = 1;
`else
        order0 = 0;
`endif
        clear_log();
        expect_burst(order0, 0);
        expect_burst(1 - order0, 0);
        pulse(2'b11, 2'b00);
        run_idle("simul1", 600);
        check_words("simul1");
        clear_log();
        expect_burst(1, 0);
        expect_burst(0, 0);
        pulse(2'b11, 2'b00);
        run_idle("simul2", 600);
        check_words("simul2");

        // Re-pulse while busy must be ignored
        clear_log();
        expect_burst(0, 0);
        pulse(2'b01, 2'b00);
        repeat (20) cyc_step(2'b00, 2'b00);
        cyc_step(2'b01, 2'b01);
        run_idle("rebusy", 400);
        repeat (10) cyc_step(2'b00, 2'b00);
        check_words("rebusy");
        chk("rebusy stays idle", req_busy, 2'b00);

        // Asynchronous reset in the middle of a long burst
        clear_log();
        pulse(2'b10, 2'b10);
        for (int n = 0; n < 200 && got.size() < 30; n++) cyc_step(2'b00, 2'b00);
        chk("midrst reached word 30", got.size(), 30);
        chk("midrst valid before", tw_valid, 2'b10);
        #1 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        expect_burst(0, 0);
        pulse(2'b01, 2'b00);
        run_idle("after_rst", 400);
        check_words("after_rst");

        // Requester 1 queued behind requester 0
        clear_log();
        expect_burst(0, 0);
        expect_burst(1, 0);
        pulse(2'b01, 2'b00);
        repeat (10) cyc_step(2'b00, 2'b00);
        cyc_step(2'b10, 2'b00);
        cyc_step(2'b00, 2'b00);
        chk("queued busy1", req_busy, 2'b11);
        run_idle("queued", 600);
        check_words("queued");
        chk("queued first word gap", first_valid[1], last_hs[0] + 3);

        // Random table choices with random backpressure
        rmode = 1;
        for (int r = 0; r < 3; r++) begin
            int id;
            bit lg;
            id = $urandom_range(0, 1);
            lg = ($urandom_range(0, 3) == 0);
            clear_log();
            expect_burst(id, lg);
            pulse(2'(1 << id), lg ? 2'(1 << id) : 2'b00);
            run_idle($sformatf("rand%0d", r), 4000);
            check_words($sformatf("rand%0d", r));
        end
        rmode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
